// File: rtl/lfsr_encrypt_stream_if.sv
// Stream bundle for lfsr_encrypt_stream.
//   char_*  : ASCII character source -> encryptor (valid/ready, char_last marks the final char)
//   out_*   : encryptor -> encrypted byte sink (valid/ready, out_idx is the byte position in the frame)
// master = environment side (char source + byte sink), slave = the encryptor.
interface lfsr_encrypt_stream_if;
  logic       char_valid;
  logic [7:0] char_data;
  logic       char_last;
  logic       char_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic [5:0] out_idx;
  logic       out_ready;

  modport master (
    output char_valid, char_data, char_last, out_ready,
    input  char_ready, out_valid, out_data, out_idx
  );

  modport slave (
    input  char_valid, char_data, char_last, out_ready,
    output char_ready, out_valid, out_data, out_idx
  );
endinterface

// File: rtl/lfsr_encrypt_stream.sv
// lfsr_encrypt_stream: frames an ASCII message into a fixed-length byte stream
// whitened by a 7-bit Fibonacci-style LFSR. A frame is: pre_length pad bytes,
// then one byte per consumed character, then pad bytes up to MSG_BYTES.
//   clk, init_n  : clock, synchronous active-low reset
//   req / ack    : frame start request / frame complete (held in DONE)
//   pre_length   : leading pad byte count (clamped to >= 10)
//   lfsr_ptrn    : LFSR feedback tap mask
//   lfsr_init    : LFSR seed (0 is replaced by 7'h01)
//   s            : char source / byte sink stream bundle (slave side)
// Build option: define ENC_PARITY_EN to put even parity in out_data[7];
// otherwise out_data[7] is 0.
module lfsr_encrypt_stream #(
  parameter int MSG_BYTES = 64,
  parameter int MAX_CHARS = 52
) (
  input  logic       clk,
  input  logic       init_n,
  input  logic       req,
  output logic       ack,
  input  logic [3:0] pre_length,
  input  logic [6:0] lfsr_ptrn,
  input  logic [6:0] lfsr_init,
  lfsr_encrypt_stream_if.slave s
);

  typedef enum logic [2:0] {IDLE, PRE, MSG, POST, DONE} state_t;

  localparam logic [5:0] LAST_IDX  = 6'(MSG_BYTES - 1);
  localparam logic [6:0] LAST_CHAR = 7'(MAX_CHARS - 1);

  state_t     state_q;
  logic [3:0] pre_q;
  logic [6:0] ptrn_q;
  logic [6:0] lfsr_q;
  logic [6:0] lfsr_d;
  logic [5:0] idx_q;
  logic [6:0] nchar_q;
  logic       ack_q;

  logic       in_msg;
  logic       active;
  logic       xfer;
  logic [7:0] char_off;
  logic [6:0] pad;
  logic [6:0] enc;
  logic       unused_char_off7;

  assign in_msg = (state_q == MSG);
  assign active = (state_q == PRE) || in_msg || (state_q == POST);

  // In MSG the byte sink and char source are tied together so every char
  // handshake is exactly one output byte in the same cycle.
  assign s.char_ready = in_msg & s.out_ready;
  assign s.out_valid  = in_msg ? s.char_valid : active;
  assign xfer         = s.out_valid & s.out_ready;

  // Wraparound subtract; only the low 7 bits are used.
  assign char_off         = s.char_data - 8'h20;
  assign unused_char_off7 = char_off[7];
  assign pad              = in_msg ? char_off[6:0] : 7'h00;
  assign enc              = pad ^ lfsr_q;

`ifdef ENC_PARITY_EN
  assign s.out_data = active ? {^enc, enc} : 8'h00;
`else
  assign s.out_data = active ? {1'b0, enc} : 8'h00;
`endif

  assign s.out_idx = idx_q;
  assign ack       = ack_q;
  assign lfsr_d    = {lfsr_q[5:0], ^(lfsr_q & ptrn_q)};

  always_ff @(posedge clk) begin
    if (!init_n) begin
      state_q <= IDLE;
      pre_q   <= '0;
      ptrn_q  <= '0;
      lfsr_q  <= '0;
      idx_q   <= '0;
      nchar_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          // DONE restarts directly on req with a fresh configuration latch.
          if (req) begin
            pre_q   <= (pre_length < 4'd10) ? 4'd10 : pre_length;
            ptrn_q  <= lfsr_ptrn;
            lfsr_q  <= (lfsr_init == 7'h00) ? 7'h01 : lfsr_init;
            idx_q   <= '0;
            nchar_q <= '0;
            ack_q   <= 1'b0;
            state_q <= PRE;
          end
        end
        PRE: begin
          if (xfer) begin
            lfsr_q <= lfsr_d;
            idx_q  <= idx_q + 6'd1;
            if (idx_q == {2'b00, pre_q} - 6'd1) state_q <= MSG;
          end
        end
        MSG: begin
          if (xfer) begin
            lfsr_q  <= lfsr_d;
            idx_q   <= idx_q + 6'd1;
            nchar_q <= nchar_q + 7'd1;
            // Frame length wins over message length: leftover chars stay unconsumed.
            if (idx_q == LAST_IDX) begin
              state_q <= DONE;
              ack_q   <= 1'b1;
            end else if (s.char_last || nchar_q == LAST_CHAR) begin
              state_q <= POST;
            end
          end
        end
        POST: begin
          if (xfer) begin
            lfsr_q <= lfsr_d;
            idx_q  <= idx_q + 6'd1;
            if (idx_q == LAST_IDX) begin
              state_q <= DONE;
              ack_q   <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_encrypt_stream.sv
module tb_lfsr_encrypt_stream;

  logic       clk;
  logic       init_n;
  logic       req;
  logic       ack;
  logic [3:0] pre_length;
  logic [6:0] lfsr_ptrn;
  logic [6:0] lfsr_init;

  lfsr_encrypt_stream_if sif();

  lfsr_encrypt_stream #(.MSG_BYTES(64), .MAX_CHARS(52)) dut (
    .clk       (clk),
    .init_n    (init_n),
    .req       (req),
    .ack       (ack),
    .pre_length(pre_length),
    .lfsr_ptrn (lfsr_ptrn),
    .lfsr_init (lfsr_init),
    .s         (sif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] msg   [0:63];
  logic [7:0] exp_b [0:63];
  logic [7:0] got_b [0:63];
  logic [5:0] got_i [0:63];
  int         got_c [0:63];
  int         nbytes;
  int         nconsumed;

  // Reference frame: pad/char bytes whitened by the LFSR, parity per build.
  function automatic void build_expected(input int pre, input logic [6:0] ptrn,
                                         input logic [6:0] init, input int nch);
    logic [6:0] st;
    logic [6:0] pad;
    logic [6:0] lo;
    logic [7:0] d;
    st = init;
    for (int k = 0; k < 64; k++) begin
      pad = 7'h00;
      if (k >= pre && (k - pre) < nch && (k - pre) < 52) begin
        d   = msg[k - pre] - 8'h20;
        pad = d[6:0];
      end
      lo = pad ^ st;
`ifdef ENC_PARITY_EN
      exp_b[k] = {^lo, lo};
`else
      exp_b[k] = {1'b0, lo};
`endif
      st = {st[5:0], ^(st & ptrn)};
    end
  endfunction

  // Drives one frame from the current state (IDLE or DONE) and logs every
  // accepted output byte. Config inputs are scrambled after req to prove latching.
  task automatic run_frame(input logic [3:0] pre, input logic [6:0] ptrn, input logic [6:0] init,
                           input int nch, input bit use_last, input bit toggle, input bit noisy_req);
    int cyc;
    int ci;
    for (int k = 0; k < 64; k++) begin
      got_b[k] = 8'hxx;
      got_i[k] = 6'hxx;
      got_c[k] = -1;
    end
    @(negedge clk);
    req = 1'b1; pre_length = pre; lfsr_ptrn = ptrn; lfsr_init = init;
    @(negedge clk);
    req = 1'b0; pre_length = 4'h0; lfsr_ptrn = 7'h7f; lfsr_init = 7'h55;
    cyc = 0; ci = 0; nbytes = 0;
    while (ack !== 1'b1 && cyc < 400) begin
      sif.out_ready  = toggle ? (cyc % 2 == 1) : 1'b1;
      sif.char_valid = (ci < nch);
      sif.char_data  = (ci < nch) ? msg[ci] : 8'h00;
      sif.char_last  = use_last && (ci == nch - 1);
      req            = noisy_req && (cyc % 3 == 1);
      #1;
      if (sif.out_valid === 1'b1 && sif.out_ready === 1'b1) begin
        if (nbytes < 64) begin
          got_b[nbytes] = sif.out_data;
          got_i[nbytes] = sif.out_idx;
          got_c[nbytes] = cyc;
        end
        nbytes++;
        if (sif.char_ready === 1'b1 && sif.char_valid === 1'b1) ci++;
      end
      @(negedge clk);
      cyc++;
    end
    req = 1'b0;
    nconsumed = ci;
    if (ack !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL frame_timeout: ack=%b after %0d cycles, required 1", ack, cyc);
    end
  endtask

  task automatic test_reset();
    init_n = 1'b0; req = 1'b0; pre_length = 4'd0; lfsr_ptrn = 7'd0; lfsr_init = 7'd0;
    sif.char_valid = 1'b0; sif.char_data = 8'h00; sif.char_last = 1'b0; sif.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (ack !== 1'b0 || sif.out_valid !== 1'b0 || sif.char_ready !== 1'b0 ||
        sif.out_idx !== 6'd0 || sif.out_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: ack=%b ov=%b cr=%b idx=%0d data=%02h, required all 0",
               ack, sif.out_valid, sif.char_ready, sif.out_idx, sif.out_data);
    end
    init_n = 1'b1;
    sif.char_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (sif.out_valid !== 1'b0 || ack !== 1'b0 || sif.char_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_quiet[%0d]: ov=%b ack=%b cr=%b, required 0 0 0",
                 i, sif.out_valid, ack, sif.char_ready);
      end
    end
    sif.char_valid = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] tbl [0:2];
`ifdef ENC_PARITY_EN
    tbl[0] = 8'h81; tbl[1] = 8'h82; tbl[2] = 8'h84;
`else
    tbl[0] = 8'h01; tbl[1] = 8'h02; tbl[2] = 8'h04;
`endif
    msg[0] = 8'h48; msg[1] = 8'h65; msg[2] = 8'h6c; msg[3] = 8'h6c; msg[4] = 8'h6f;
    run_frame(4'd10, 7'h60, 7'h01, 5, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (got_b[k] !== tbl[k] || got_i[k] !== 6'(k) || got_c[k] != k) begin
        n_fail++;
        $display("FAIL basic_byte[%0d]: data=%02h idx=%0d cyc=%0d, required data=%02h idx=%0d cyc=%0d",
                 k, got_b[k], got_i[k], got_c[k], tbl[k], k, k);
      end
    end
    n_checks++;
    if (nbytes != 64 || nconsumed != 5) begin
      n_fail++;
      $display("FAIL basic_count: bytes=%0d chars=%0d, required 64 5", nbytes, nconsumed);
    end
  endtask

  task automatic test_back_to_back();
    string s;
    n_checks++;
    if (ack !== 1'b1) begin
      n_fail++;
      $display("FAIL done_ack_hold: ack=%b, required 1", ack);
    end
    s = "Mr. Watson, come here. I want to see you.";
    for (int i = 0; i < 41; i++) msg[i] = s[i];
    run_frame(4'd12, 7'h60, 7'h01, 41, 1'b1, 1'b0, 1'b0);
    build_expected(12, 7'h60, 7'h01, 41);
    n_checks++;
    if (got_c[0] != 0 || got_b[0] !== exp_b[0]) begin
      n_fail++;
      $display("FAIL b2b_first: cyc=%0d data=%02h, required cyc=0 data=%02h", got_c[0], got_b[0], exp_b[0]);
    end
  endtask

  task automatic test_message();
    build_expected(12, 7'h60, 7'h01, 41);
    for (int k = 0; k < 64; k++) begin
      n_checks++;
      if (got_b[k] !== exp_b[k] || got_i[k] !== 6'(k)) begin
        n_fail++;
        $display("FAIL msg_byte[%0d]: data=%02h idx=%0d, required data=%02h idx=%0d",
                 k, got_b[k], got_i[k], exp_b[k], k);
      end
    end
    n_checks++;
    if (nbytes != 64 || nconsumed != 41) begin
      n_fail++;
      $display("FAIL msg_count: bytes=%0d chars=%0d, required 64 41", nbytes, nconsumed);
    end
  endtask

  task automatic test_truncate();
    for (int i = 0; i < 64; i++) msg[i] = 8'(i * 37 + 5);
    run_frame(4'd15, 7'h60, 7'h01, 52, 1'b0, 1'b0, 1'b0);
    build_expected(15, 7'h60, 7'h01, 52);
    for (int k = 0; k < 64; k++) begin
      n_checks++;
      if (got_b[k] !== exp_b[k] || got_i[k] !== 6'(k)) begin
        n_fail++;
        $display("FAIL trunc_byte[%0d]: data=%02h idx=%0d, required data=%02h idx=%0d",
                 k, got_b[k], got_i[k], exp_b[k], k);
      end
    end
    #1;
    n_checks++;
    if (nbytes != 64 || nconsumed != 49 || sif.char_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL trunc_count: bytes=%0d chars=%0d cr=%b, required 64 49 0",
               nbytes, nconsumed, sif.char_ready);
    end
    sif.char_valid = 1'b0;
  endtask

  task automatic test_max_chars();
    run_frame(4'd10, 7'h41, 7'h2a, 60, 1'b0, 1'b0, 1'b0);
    build_expected(10, 7'h41, 7'h2a, 60);
    for (int k = 0; k < 64; k++) begin
      n_checks++;
      if (got_b[k] !== exp_b[k] || got_i[k] !== 6'(k)) begin
        n_fail++;
        $display("FAIL max_byte[%0d]: data=%02h idx=%0d, required data=%02h idx=%0d",
                 k, got_b[k], got_i[k], exp_b[k], k);
      end
    end
    n_checks++;
    if (nbytes != 64 || nconsumed != 52) begin
      n_fail++;
      $display("FAIL max_count: bytes=%0d chars=%0d, required 64 52", nbytes, nconsumed);
    end
    sif.char_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    string s;
    s = "Mr. Watson, come here. I want to see you.";
    for (int i = 0; i < 41; i++) msg[i] = s[i];
    run_frame(4'd12, 7'h60, 7'h01, 41, 1'b1, 1'b1, 1'b1);
    build_expected(12, 7'h60, 7'h01, 41);
    for (int k = 0; k < 64; k++) begin
      n_checks++;
      if (got_b[k] !== exp_b[k] || got_i[k] !== 6'(k)) begin
        n_fail++;
        $display("FAIL bp_byte[%0d]: data=%02h idx=%0d, required data=%02h idx=%0d",
                 k, got_b[k], got_i[k], exp_b[k], k);
      end
    end
    n_checks++;
    if (nbytes != 64 || nconsumed != 41) begin
      n_fail++;
      $display("FAIL bp_count: bytes=%0d chars=%0d, required 64 41", nbytes, nconsumed);
    end
  endtask

  task automatic test_init_zero();
    msg[0] = 8'h5a; msg[1] = 8'h21; msg[2] = 8'h7e; msg[3] = 8'h20; msg[4] = 8'hc1;
    run_frame(4'd3, 7'h60, 7'h00, 5, 1'b1, 1'b0, 1'b0);
    build_expected(10, 7'h60, 7'h01, 5);
    for (int k = 0; k < 64; k++) begin
      n_checks++;
      if (got_b[k] !== exp_b[k] || got_i[k] !== 6'(k)) begin
        n_fail++;
        $display("FAIL init0_byte[%0d]: data=%02h idx=%0d, required data=%02h idx=%0d",
                 k, got_b[k], got_i[k], exp_b[k], k);
      end
    end
  endtask

  task automatic test_midreset();
    int cyc;
    cyc = 0;
    @(negedge clk);
    req = 1'b1; pre_length = 4'd10; lfsr_ptrn = 7'h60; lfsr_init = 7'h01;
    @(negedge clk);
    req = 1'b0;
    sif.out_ready = 1'b1; sif.char_valid = 1'b1; sif.char_data = 8'h41; sif.char_last = 1'b0;
    #1;
    while (sif.out_idx !== 6'd30 && cyc < 100) begin
      @(negedge clk); #1; cyc++;
    end
    n_checks++;
    if (sif.out_idx !== 6'd30) begin
      n_fail++;
      $display("FAIL midreset_reach: idx=%0d, required 30", sif.out_idx);
    end
    init_n = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if (sif.out_valid !== 1'b0 || ack !== 1'b0 || sif.char_ready !== 1'b0 ||
        sif.out_idx !== 6'd0 || sif.out_data !== 8'h00) begin
      n_fail++;
      $display("FAIL midreset_state: ov=%b ack=%b cr=%b idx=%0d data=%02h, required all 0",
               sif.out_valid, ack, sif.char_ready, sif.out_idx, sif.out_data);
    end
    init_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (sif.out_valid !== 1'b0 || ack !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_idle: ov=%b ack=%b, required 0 0", sif.out_valid, ack);
    end
    sif.char_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_message();
    test_truncate();
    test_max_chars();
    test_backpressure();
    test_init_zero();
    test_midreset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
